dv_checkpoint_monitor: RTL

Synthesizable, parametrised checkpoint monitor for management-SoC bring-up and gate-level test. It watches a 16-bit firmware status word (normally `la_output[31:16]`) and decodes start, pass and fail codes for up to NPHASE test phases. It tracks each phase, applies a global timeout and reports a single overall verdict. Each accepted checkpoint is also pushed into a small event FIFO, so a bench or on-chip logger can drain the event stream.

---
 rtl/dv_mon_pkg.sv | 56 +++++
 rtl/dv_mon_evt_fifo.sv | 60 ++++++
 rtl/dv_checkpoint_monitor.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dv_mon_pkg.sv
// dv_mon_pkg: shared definitions for the checkpoint monitor.
//   - checkpoint tag bytes and the timeout event code
//   - monitor verdict state enum
//   - decode_code(): splits a status word into {kind, slot, legal}
package dv_mon_pkg;

  localparam logic [7:0]  TAG_START   = 8'hA0;
  localparam logic [7:0]  TAG_RESULT  = 8'hAB;
  localparam logic [15:0] EVT_TIMEOUT = 16'hDEAD;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } mon_state_e;

  typedef enum logic [1:0] {
    KIND_NONE,
    KIND_START,
    KIND_PASS,
    KIND_FAIL
  } code_kind_e;

  typedef struct packed {
    code_kind_e kind;
    logic [3:0] slot;
    logic       legal;
  } code_info_t;

  // kind is KIND_NONE only for untagged words; a tagged word with bad
  // fields keeps a tagged kind but legal=0 so the caller can flag it.
  function automatic code_info_t decode_code(input logic [15:0] code,
                                             input int unsigned nphase);
    code_info_t info;
    logic [3:0] p;
    logic [3:0] r;
    p          = code[7:4];
    r          = code[3:0];
    info.kind  = KIND_NONE;
    info.slot  = p - 4'd1;
    info.legal = 1'b0;
    if (code[15:8] == TAG_START) begin
      info.kind  = KIND_START;
      info.legal = (r == 4'd0);
    end else if (code[15:8] == TAG_RESULT) begin
      info.kind  = (r == 4'd1) ? KIND_PASS : KIND_FAIL;
      info.legal = (r <= 4'd1);
    end
    if ((p == 4'd0) || (32'(p) > nphase)) begin
      info.legal = 1'b0;
    end
    return info;
  endfunction

endpackage

// File: rtl/dv_mon_evt_fifo.sv
// dv_mon_evt_fifo: synchronous event FIFO for the checkpoint monitor.
//   clk, rst_n : clock, synchronous active-low reset
//   push, data : write request and 16-bit event code
//   full       : no free entry
//   pop        : consume head entry (ignored when empty)
//   valid      : FIFO not empty
//   head       : entry at the read pointer
// A push while full only lands when a pop happens on the same edge.
module dv_mon_evt_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [15:0] data,
  output logic        full,
  input  logic        pop,
  output logic        valid,
  output logic [15:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]                wptr_q, wptr_d;
  logic [AW:0]                rptr_q, rptr_d;
  logic [DEPTH-1:0][15:0]     mem_q, mem_d;
  logic                       do_pop;
  logic                       do_push;

  always_comb begin
    valid   = (wptr_q != rptr_q);
    full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    head    = mem_q[rptr_q[AW-1:0]];
    do_pop  = pop && valid;
    do_push = push && (!full || do_pop);
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (do_push) begin
      mem_d[wptr_q[AW-1:0]] = data;
      wptr_d                = wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      mem_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/dv_checkpoint_monitor.sv
// dv_checkpoint_monitor: decodes firmware checkpoint codes from a 16-bit
// status word, tracks per-phase start/pass/fail, applies a global timeout
// and reports a sticky overall verdict. Accepted checkpoints are queued in
// an event FIFO.
//   core_clk, core_rstn      : clock, synchronous active-low reset
//   checkbits                : firmware status word
//   evt_ready                : consumer takes the head event
//   phase_sel                : slot index for phase_cycles
//   done/pass/fail/timeout   : verdict flags (sticky)
//   bad_code                 : malformed or out-of-order code (sticky)
//   phase_started/passed/failed : per-slot status
//   evt_valid, evt_code      : event FIFO head
//   evt_overflow             : an event was dropped (sticky)
//   phase_cycles             : start-to-result cycles of slot phase_sel
// Build option: define MON_CYCLE_COUNT_EN for per-slot cycle counters;
// otherwise phase_cycles reads 0.
module dv_checkpoint_monitor
  import dv_mon_pkg::*;
#(
  parameter int unsigned       NPHASE         = 4,
  parameter logic [NPHASE-1:0] PHASE_MASK     = NPHASE'(4'hF),
  parameter int unsigned       TIMEOUT_CYCLES = 400000,
  parameter int unsigned       EVT_DEPTH      = 4
) (
  input  logic              core_clk,
  input  logic              core_rstn,
  input  logic [15:0]       checkbits,
  input  logic              evt_ready,
  input  logic [3:0]        phase_sel,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic              bad_code,
  output logic [NPHASE-1:0] phase_started,
  output logic [NPHASE-1:0] phase_passed,
  output logic [NPHASE-1:0] phase_failed,
  output logic              evt_valid,
  output logic [15:0]       evt_code,
  output logic              evt_overflow,
  output logic [31:0]       phase_cycles
);

  mon_state_e        state_q, state_d;
  logic [15:0]       chk_q, chk_d;
  logic [15:0]       last_code_q, last_code_d;
  logic [NPHASE-1:0] started_q, started_d;
  logic [NPHASE-1:0] passed_q, passed_d;
  logic [NPHASE-1:0] failed_q, failed_d;
  logic              bad_q, bad_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       tmo_cnt_q, tmo_cnt_d;

  code_info_t        info;
  logic [NPHASE-1:0] slot_oh;
  logic              run;
  logic              act;
  logic              start_acc;
  logic              pass_acc;
  logic              fail_acc;
  logic              tmo_enter;
  logic              push_req;
  logic              push_ok;
  logic [15:0]       push_data;
  logic              fifo_full;
  logic              pop;

  always_comb begin
    run         = (state_q == ST_RUN);
    chk_d       = checkbits;
    info        = decode_code(checkbits, NPHASE);
    slot_oh     = NPHASE'(1) << info.slot;
    // Qualified (stable for two samples) and not already acted upon.
    last_code_d = last_code_q;
    act         = 1'b0;
    if ((checkbits == chk_q) && (checkbits != last_code_q)) begin
      last_code_d = checkbits;
      act         = run;
    end

    start_acc = act && info.legal && (info.kind == KIND_START) && ((started_q & slot_oh) == '0);
    pass_acc  = act && info.legal && (info.kind == KIND_PASS) && ((passed_q & slot_oh) == '0);
    fail_acc  = act && info.legal && (info.kind == KIND_FAIL);

    started_d = started_q | (start_acc ? slot_oh : '0);
    passed_d  = passed_q  | (pass_acc  ? slot_oh : '0);
    failed_d  = failed_q  | (fail_acc  ? slot_oh : '0);
    bad_d     = bad_q
              | (act && (info.kind != KIND_NONE) && !info.legal)
              | (pass_acc && ((started_q & slot_oh) == '0));

    tmo_cnt_d = run ? (tmo_cnt_q + 32'd1) : tmo_cnt_q;

    state_d = state_q;
    if (run) begin
      if (fail_acc) begin
        state_d = ST_FAIL;
      end else if ((passed_d & PHASE_MASK) == PHASE_MASK) begin
        state_d = ST_PASS;
      end else if (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 2)) begin
        state_d = ST_TIMEOUT;
      end
    end
    tmo_enter = run && (state_d == ST_TIMEOUT);

    // A checkpoint landing on the timeout edge still updates status, but
    // the FIFO slot goes to the timeout marker.
    push_req  = start_acc || pass_acc || fail_acc || tmo_enter;
    push_data = tmo_enter ? EVT_TIMEOUT : checkbits;
    pop       = evt_valid && evt_ready;
    push_ok   = push_req && (!fifo_full || pop);
    ovf_d     = ovf_q || (push_req && fifo_full && !pop);
  end

  always_ff @(posedge core_clk) begin
    if (!core_rstn) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge core_clk) begin
    if (!core_rstn) begin
      chk_q       <= '0;
      last_code_q <= '0;
      started_q   <= '0;
      passed_q    <= '0;
      failed_q    <= '0;
      bad_q       <= 1'b0;
      ovf_q       <= 1'b0;
      tmo_cnt_q   <= '0;
    end else begin
      chk_q       <= chk_d;
      last_code_q <= last_code_d;
      started_q   <= started_d;
      passed_q    <= passed_d;
      failed_q    <= failed_d;
      bad_q       <= bad_d;
      ovf_q       <= ovf_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  dv_mon_evt_fifo #(
    .DEPTH (EVT_DEPTH)
  ) u_evt_fifo (
    .clk   (core_clk),
    .rst_n (core_rstn),
    .push  (push_ok),
    .data  (push_data),
    .full  (fifo_full),
    .pop   (pop),
    .valid (evt_valid),
    .head  (evt_code)
  );

`ifdef MON_CYCLE_COUNT_EN
  logic [NPHASE-1:0][31:0] cyc_q, cyc_d;

  // The result edge itself still counts; the counter freezes afterwards.
  always_comb begin
    cyc_d = cyc_q;
    for (int unsigned i = 0; i < NPHASE; i++) begin
      if (start_acc && slot_oh[i]) begin
        cyc_d[i] = '0;
      end else if (run && started_q[i] && !passed_q[i] && !failed_q[i] && (cyc_q[i] != '1)) begin
        cyc_d[i] = cyc_q[i] + 32'd1;
      end
    end
    phase_cycles = '0;
    for (int unsigned i = 0; i < NPHASE; i++) begin
      if (32'(phase_sel) == i) begin
        phase_cycles = cyc_q[i];
      end
    end
  end

  always_ff @(posedge core_clk) begin
    if (!core_rstn) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end
`else
  logic unused_phase_sel;
  assign unused_phase_sel = ^phase_sel;
  assign phase_cycles     = '0;
`endif

  assign done          = (state_q != ST_RUN);
  assign pass          = (state_q == ST_PASS);
  assign fail          = (state_q == ST_FAIL);
  assign timeout       = (state_q == ST_TIMEOUT);
  assign bad_code      = bad_q;
  assign phase_started = started_q;
  assign phase_passed  = passed_q;
  assign phase_failed  = failed_q;
  assign evt_overflow  = ovf_q;

endmodule
